// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM channel scheduler: channel/requester
// counts, default counter geometry and the per-pair priority pointer type.
package pwm_pkg;

  localparam int NUM_CH     = 4;
  localparam int REQ_PER_CH = 2;
  localparam int NUM_REQ    = NUM_CH * REQ_PER_CH;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_PERIOD = 255;

  // Which requester of a pair wins when both are asking.
  typedef enum logic {
    PRI_EVEN = 1'b0,
    PRI_ODD  = 1'b1
  } pri_e;

endpackage

// File: rtl/pwm_pair_arbiter.sv
// Two-way round-robin arbiter for one PWM channel. It updates the grant pair,
// the latched duty and the priority pointer only on the period wrap strobe.
module pwm_pair_arbiter
  import pwm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrap,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] duty_even,
  input  logic [CNT_W-1:0] duty_odd,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] duty
);

  pri_e ptr;
  logic win_odd;

  // A lone requester always wins; the pointer only matters on a tie.
  always_comb begin
    win_odd = (req == 2'b11) ? (ptr == PRI_ODD) : req[1];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= PRI_EVEN;
      grant <= '0;
      duty  <= '0;
    end else if (wrap) begin
      if (req == 2'b00) begin
        grant <= '0;
        duty  <= '0;
      end else begin
        grant <= win_odd ? 2'b10 : 2'b01;
        duty  <= win_odd ? duty_odd : duty_even;
        ptr   <= win_odd ? PRI_EVEN : PRI_ODD;
      end
    end
  end

endmodule

// File: rtl/pwm_channel_scheduler.sv
// Shares four PWM channels among eight paired requesters. A shared period
// counter drives every channel; arbitration happens once per period at wrap.
module pwm_channel_scheduler
  import pwm_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] duty_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic                     period_start
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(PERIOD);

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic [CNT_W-1:0] duty_reg [NUM_CH];

  assign wrap         = (cnt == TERM);
  assign period_start = (cnt == '0);

  // Reset parks the counter at the terminal count so the first edge after
  // release is an arbitration edge.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= TERM;
    else if (wrap) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pwm_pair_arbiter #(
      .CNT_W(CNT_W)
    ) u_arb (
      .clk      (clk),
      .rst      (rst),
      .wrap     (wrap),
      .req      (req[REQ_PER_CH*k +: REQ_PER_CH]),
      .duty_even(duty_in[(REQ_PER_CH*k)*CNT_W +: CNT_W]),
      .duty_odd (duty_in[(REQ_PER_CH*k+1)*CNT_W +: CNT_W]),
      .grant    (grant[REQ_PER_CH*k +: REQ_PER_CH]),
      .duty     (duty_reg[k])
    );
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pwm_out = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pwm_out[k] = (|grant[REQ_PER_CH*k +: REQ_PER_CH]) && (cnt < duty_reg[k]);
    end
  end

endmodule

// File: tb/tb_pwm_channel_scheduler.sv
// Directed bench for pwm_channel_scheduler with PERIOD=9 (10-cycle periods).
// Expected grants and per-channel high times are hand-derived per step.
module tb_pwm_channel_scheduler;

  localparam int CNT_W  = 8;
  localparam int PERIOD = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   req;
  logic [63:0]  duty_in;
  logic [7:0]   grant;
  logic [3:0]   pwm_out;
  logic         period_start;

  int checks = 0;
  int errors = 0;

  pwm_channel_scheduler #(
    .CNT_W (CNT_W),
    .PERIOD(PERIOD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .duty_in     (duty_in),
    .grant       (grant),
    .pwm_out     (pwm_out),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_duty(input int i, input logic [7:0] v);
    duty_in[i*8 +: 8] = v;
  endtask

  // hi holds the number of high cycles per channel, {ch3, ch2, ch1, ch0}.
  task automatic check_cycle(input int c, input logic [7:0] gexp, input logic [3:0][7:0] hi);
    logic [3:0] pexp;
    pexp = '0;
    for (int k = 0; k < 4; k++) pexp[k] = (c < int'(hi[k]));
    check($sformatf("grant@%0d", c), grant, gexp);
    check($sformatf("pwm@%0d", c), {4'b0, pwm_out}, {4'b0, pexp});
    check($sformatf("pstart@%0d", c), {7'b0, period_start}, {7'b0, (c == 0)});
  endtask

  // Called at cnt==0; returns at cnt==PERIOD without crossing the wrap.
  task automatic check_period(input logic [7:0] gexp, input logic [3:0][7:0] hi);
    for (int c = 0; c <= PERIOD; c++) begin
      check_cycle(c, gexp, hi);
      if (c < PERIOD) tick();
    end
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    duty_in = '0;

    // Reset held for three cycles.
    tick(); tick(); tick();
    check("rst_grant", grant, 8'h00);
    check("rst_pwm", {4'b0, pwm_out}, 8'h00);
    check("rst_pstart", {7'b0, period_start}, 8'h00);

    // First period: only requester 0, duty 4.
    set_duty(0, 8'd4);
    req = 8'h01;
    rst = 1'b0;
    tick();
    check_period(8'h01, {8'd0, 8'd0, 8'd0, 8'd4});

    // Fresh pointer, then fairness on channel 0 over four periods.
    rst = 1'b1;
    tick();
    req = 8'h03;
    set_duty(0, 8'd3);
    set_duty(1, 8'd7);
    rst = 1'b0;
    tick();
    check_period(8'h01, {8'd0, 8'd0, 8'd0, 8'd3});
    tick();
    check_period(8'h02, {8'd0, 8'd0, 8'd0, 8'd7});
    tick();
    check_period(8'h01, {8'd0, 8'd0, 8'd0, 8'd3});
    tick();
    check_period(8'h02, {8'd0, 8'd0, 8'd0, 8'd7});

    // Mid-period request drop and duty change on requester 2 are ignored.
    req = 8'h04;
    set_duty(2, 8'd5);
    tick();
    for (int c = 0; c <= PERIOD; c++) begin
      check_cycle(c, 8'h04, {8'd0, 8'd0, 8'd5, 8'd0});
      if (c == 2) begin
        req = 8'h00;
        set_duty(2, 8'd1);
      end
      if (c < PERIOD) tick();
    end
    tick();
    check_period(8'h00, {8'd0, 8'd0, 8'd0, 8'd0});

    // Boundary duties, all eight requesting. Channel 1 pointer sits on the
    // odd side after the lone win of requester 2, so requester 3 (duty 9) wins.
    req = 8'hFF;
    set_duty(0, 8'd0);   set_duty(1, 8'd5);
    set_duty(2, 8'd9);   set_duty(3, 8'd9);
    set_duty(4, 8'd10);  set_duty(5, 8'd5);
    set_duty(6, 8'd255); set_duty(7, 8'd5);
    tick();
    check_period(8'h59, {8'd10, 8'd10, 8'd9, 8'd0});

    // Pointers alternate; reset lands at cnt=5 with active grants.
    tick();
    for (int c = 0; c <= 5; c++) begin
      check_cycle(c, 8'hA6, {8'd5, 8'd5, 8'd9, 8'd5});
      if (c < 5) tick();
    end
    rst = 1'b1;
    tick();
    check("midrst_grant", grant, 8'h00);
    check("midrst_pwm", {4'b0, pwm_out}, 8'h00);
    check("midrst_pstart", {7'b0, period_start}, 8'h00);
    rst = 1'b0;
    tick();
    check_period(8'h55, {8'd10, 8'd10, 8'd9, 8'd0});

    // Lone requester 7 moves channel 3's pointer to requester 6.
    req = 8'h80;
    tick();
    check_period(8'h80, {8'd5, 8'd0, 8'd0, 8'd0});
    req = 8'hC0;
    tick();
    check_period(8'h40, {8'd10, 8'd0, 8'd0, 8'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_channel_scheduler.md
Name: pwm_channel_scheduler

Overview:
Shares four PWM output channels among eight requesters. Requesters are grouped in pairs: requesters 2k and 2k+1 compete for channel k, which is the same 8-to-4 pairing the PWM generator's merge stage uses. Once per PWM period, each channel grants its pair by round-robin, latches the winner's duty value and drives the channel output from a shared period counter. The block sits between the switch/duty configuration logic and the PWM output pins.

Parameters:
CNT_W, 8, width of the period counter and of each duty value
PERIOD, 255, terminal count; one period lasts PERIOD+1 clk cycles (legal range 1..2^CNT_W-1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  8  request lines; bit i belongs to requester i
duty_in  in  8*CNT_W  packed duty values; slice [i*CNT_W +: CNT_W] is requester i
grant  out  8  one-hot-per-pair grant; grant[i]=1 means requester i owns channel i/2 this period
pwm_out  out  4  PWM output per channel
period_start  out  1  high for the single cycle where cnt==0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values on the first edge with rst=1: cnt=PERIOD, grant=0, duty_reg[0..3]=0, ptr[0..3]=0 (even requester has priority), pwm_out=0, period_start=0.
- Counter: cnt increments by 1 each cycle. When cnt==PERIOD, it wraps to 0 on the next edge.
- Arbitration instant: only on the edge where cnt goes from PERIOD to 0. The first edge after rst deasserts is therefore an arbitration edge, and the first grant is visible one cycle after reset release.
- Per channel k, at the arbitration instant, using the sampled req[2k+1:2k] and ptr[k]:
  - both requesting: grant the requester selected by ptr[k], then set ptr[k] to the other requester.
  - one requesting: grant it, and set ptr[k] to the non-winner.
  - none requesting: grant bits for the pair are 0, duty_reg[k]=0, ptr[k] is unchanged.
  - A winner's duty_in slice is latched into duty_reg[k] on the same edge.
- Stability: grant and duty_reg hold for the whole period. req and duty_in changes mid-period, including request drops, are ignored until the next arbitration.
- Output: pwm_out[k] = (|grant[2k+1:2k]) & (cnt < duty_reg[k]). This is combinational from registers, so it has no added latency.
  - duty 0 gives a constant low.
  - duty > PERIOD gives a constant high for the whole period (natural clamp).
  - duty == PERIOD+1 when representable also gives a constant high.
- period_start = (cnt==0). It is combinational from the cnt register.
- Reset mid-period: all state returns to reset values on that edge and outputs go low immediately after it. Arbitration restarts on the first edge after release.
- At most one grant bit per pair is ever high. Channels are independent.
- Arithmetic: cnt and duty are unsigned CNT_W bits, and the comparison is unsigned. The counter never exceeds PERIOD.

Decomposition:
- Shared package pwm_pkg:
  - NUM_CH=4
  - REQ_PER_CH=2
  - NUM_REQ=8
  - default CNT_W and PERIOD
- Sub-module pwm_pair_arbiter, instantiated four times in a generate loop. It holds the 2-way round-robin pointer, the grant pair and the duty register, and is updated on a "wrap" strobe supplied by the top level.
- The top level owns the counter, the wrap strobe, period_start and pwm_out.

Test Plan:
- Reset and first period (PERIOD=9): hold rst for 3 cycles, then release with req=0x01 and duty slice0=4.
  - Required: one cycle after release, grant=0x01 and period_start=1.
  - pwm_out[0] is high for cnt 0..3 and low for cnt 4..9. Other channels stay low.
- Round-robin fairness: req[1:0]=2'b11 held for 4 periods.
  - Required: grant[1:0] sequence is 01, 10, 01, 10.
  - Each period uses the matching duty slice (e.g. 3 and 7, giving high times of 3 and 7 cycles).
- Mid-period changes ignored: drop req[2] and change its duty from 5 to 1 at cnt=2.
  - Required: grant[2] and the 5-cycle high time persist through cnt=9.
  - At the next wrap, grant[3:2]=00 and pwm_out[1] is constantly low.
- Boundary duties with all eight requesting: duties 0, 9, 10 and 255 on the even requesters.
  - Required: channel 0 constant low.
  - Channel 1 high for 9 of 10 cycles.
  - Channels 2 and 3 constant high.
- Reset mid-operation: assert rst at cnt=5 with active grants.
  - Required: grant=0 and pwm_out=0 the next cycle.
  - After release, ptr resets so the even requester wins when both request.
- Single-requester pointer: only req[7] is active for one period, then req[7:6]=11.
  - Required: grant[7] in the first period, grant[6] in the second, because the pointer moved to the non-winner.
